// File: rtl/val_disp_pkg.sv
// val_disp_pkg: shared definitions for the value display block.
//   - conv_state_e : binary-to-BCD converter FSM states
//   - SEG_*        : 7-segment patterns (seg[0]=a .. seg[6]=g, active-high)
//   - DIG_*        : digit-index encodings for the scan multiplexer
//   - dd_adjust    : double-dabble nibble correction
package val_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;

    // A nibble >= 5 would overflow past 9 when doubled; adding 3 first
    // makes the shift carry into the next decimal digit instead.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/val_disp_seg7_dec.sv
// seg7_dec: combinational BCD nibble to 7-segment decoder.
//   nib : 4-bit digit value
//   seg : segment pattern; values above 9 show a dash
module seg7_dec
    import val_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/val_disp.sv
// val_disp: shows an unsigned binary value on a 3-digit multiplexed
// 7-segment display. A double-dabble FSM converts each new value to BCD
// one bit per cycle; only the finished result is copied to the display
// digit registers. A prescaler scans the three digits with leading-zero
// blanking.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   val  : WIDTH-bit value to display
//   seg  : registered segment drive (a..g on bits 0..6)
//   an   : registered one-hot digit select (units, tens, hundreds)
//   busy : conversion in progress
module val_disp
    import val_disp_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int SCAN_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] val,
    output logic [6:0]       seg,
    output logic [2:0]       an,
    output logic             busy
);

    localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [3:0]     LAST_ITER = 4'(WIDTH - 1);

    conv_state_e      state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [11:0]      disp_q, disp_d;   // {hundreds, tens, units}
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       dig_q, dig_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             start;
    logic [11:0]      bcd_adj;
    logic [3:0]       sel_nib;
    logic [6:0]       dec_seg;
    logic             blank;

    assign start = (state_q == ST_IDLE) && (val != last_q);

    // State / datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            opnd_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            pre_q   <= '0;
            dig_q   <= DIG_UNITS;
            an_q    <= 3'b001;
            seg_q   <= SEG_0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            opnd_q  <= opnd_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            pre_q   <= pre_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_ITER) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Converter datapath and outputs
    always_comb begin
        last_d  = last_q;
        opnd_d  = opnd_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        bcd_adj = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_d = val;
                    opnd_d = val;
                    bcd_d  = '0;
                    cnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                {bcd_d, opnd_d} = {bcd_adj, opnd_q} << 1;
                cnt_d           = cnt_q + 4'd1;
            end
            ST_DONE: disp_d = bcd_q;
            default: ;
        endcase
    end

    // Scan prescaler, digit select and output register inputs. The output
    // registers are fed from the next digit index and next display value,
    // so an/seg always match dig_q/disp_q in the same cycle.
    always_comb begin
        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
        dig_d = dig_q;
        if (pre_q == PRE_MAX) begin
            dig_d = (dig_q == DIG_HUNDS) ? DIG_UNITS : dig_q + 2'd1;
        end

        case (dig_d)
            DIG_TENS:  sel_nib = disp_d[7:4];
            DIG_HUNDS: sel_nib = disp_d[11:8];
            default:   sel_nib = disp_d[3:0];
        endcase

        blank = 1'b0;
        if (dig_d == DIG_HUNDS && disp_d[11:8] == 4'd0) blank = 1'b1;
        if (dig_d == DIG_TENS && disp_d[11:4] == 8'd0)  blank = 1'b1;

        an_d  = 3'b001 << dig_d;
        seg_d = blank ? SEG_BLANK : dec_seg;
    end

    seg7_dec u_dec (
        .nib (sel_nib),
        .seg (dec_seg)
    );

    assign an  = an_q;
    assign seg = seg_q;

endmodule
